instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch.sv | 140 ++++++++++++++
 tb/tb_instruction_fetch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage: holds the PC and issues one instruction-memory read at a time.
// Each fetched word goes to decode through a single-entry valid/ready buffer.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] instruction_pc,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] req_addr;
  logic        req;
  logic [31:0] buf_data;
  logic [31:0] buf_pc;
  logic        buf_valid;
  logic        fault;

  logic        pop;
  logic        issue;
  logic        accept;

  assign pop    = buf_valid & instruction_ready;
  // A new request needs a quiet cycle: no redirect, no fault, and room in the buffer.
  assign issue  = (state == IDLE) & ~redirect_valid & ~fault & (~buf_valid | pop);
  // Only an ack in FETCH delivers data; a same-cycle redirect discards it.
  assign accept = (state == FETCH) & imem_ack & ~redirect_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (issue) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (imem_ack) begin
          state_next = IDLE;
        end else if (redirect_valid) begin
          state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (imem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request flop tracks the next state so imem_req is a clean register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req      <= 1'b0;
      req_addr <= RESET_PC;
    end else begin
      req <= (state_next != IDLE);
      if (issue) begin
        req_addr <= pc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= redirect_pc;
    end else if (accept) begin
      pc <= pc + 32'd4;
    end
  end

  // Output buffer: redirect squashes, fresh data loads, pop drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_data  <= 32'd0;
      buf_pc    <= 32'd0;
      buf_valid <= 1'b0;
    end else if (redirect_valid) begin
      buf_valid <= 1'b0;
    end else if (accept) begin
      buf_data  <= imem_rdata;
      buf_pc    <= req_addr;
      buf_valid <= 1'b1;
    end else if (pop) begin
      buf_valid <= 1'b0;
    end
  end

  // Sticky until an aligned redirect arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault <= 1'b0;
    end else if (redirect_valid) begin
      fault <= (redirect_pc[1:0] != 2'b00);
    end
  end

  // Output logic
  always_comb begin
    imem_req          = req;
    imem_addr         = req_addr;
    instruction       = buf_data;
    instruction_pc    = buf_pc;
    instruction_valid = buf_valid;
    fetch_fault       = fault;
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios with literal
// expectations, then randomized traffic against a request-level reference model.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] instruction_pc;
  logic        instruction_valid;
  logic        instruction_ready;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  // Reference model: next PC, one outstanding-request record, buffer, fault flag.
  logic [31:0] m_pc, m_addr, m_instr, m_ipc;
  logic        m_req, m_doomed, m_valid, m_fault;

  instruction_fetch #(.RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .instruction_valid (instruction_valid),
    .instruction_ready (instruction_ready),
    .fetch_fault       (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pc = RST_PC; m_addr = RST_PC; m_instr = 32'd0; m_ipc = 32'd0;
    m_req = 1'b0; m_doomed = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs presented this cycle.
  function automatic void model_update();
    logic        pop_now;
    logic        load;
    logic        issue_now;
    logic [31:0] old_pc;
    pop_now   = m_valid & instruction_ready;
    load      = 1'b0;
    issue_now = !m_req && !redirect_valid && !m_fault && (!m_valid || pop_now);
    old_pc    = m_pc;
    if (pop_now)
      $display("xfer pc=%h instr=%h", m_ipc, m_instr);
    if (m_req && imem_ack) begin
      load  = !m_doomed && !redirect_valid;
      m_req = 1'b0;
    end else if (m_req && redirect_valid) begin
      m_doomed = 1'b1;
    end
    if (redirect_valid) m_valid = 1'b0;
    else if (load) begin
      m_valid = 1'b1; m_instr = imem_rdata; m_ipc = m_addr;
    end else if (pop_now) m_valid = 1'b0;
    m_pc = redirect_valid ? redirect_pc : (load ? old_pc + 32'd4 : old_pc);
    if (redirect_valid) m_fault = (redirect_pc[1:0] != 2'b00);
    if (issue_now) begin
      m_req = 1'b1; m_addr = old_pc; m_doomed = 1'b0;
    end
  endfunction

  function automatic void compare_model();
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    chk("imem_addr", imem_addr, m_addr);
    chk("instruction_valid", {31'd0, instruction_valid}, {31'd0, m_valid});
    chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
    if (m_valid) begin
      chk("instruction", instruction, m_instr);
      chk("instruction_pc", instruction_pc, m_ipc);
    end
  endfunction

  // Called at a negedge: drive inputs, take one edge, check at the next negedge.
  task automatic step(input logic r, input logic [31:0] rpc, input logic ack, input logic rdy);
    redirect_valid    = r;
    redirect_pc       = rpc;
    imem_ack          = ack;
    instruction_ready = rdy;
    imem_rdata        = $urandom;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare_model();
  endtask

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk(name, got, exp);
  endtask

  initial begin
    logic        r, ack, rdy;
    logic [31:0] rpc;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; instruction_ready = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    lit("rst_req", {31'd0, imem_req}, 32'd0);
    lit("rst_addr", imem_addr, 32'h100);
    lit("rst_valid", {31'd0, instruction_valid}, 32'd0);
    lit("rst_instr", instruction, 32'd0);
    lit("rst_ipc", instruction_pc, 32'd0);
    lit("rst_fault", {31'd0, fetch_fault}, 32'd0);
    rst_n = 1'b1;

    // Zero-wait memory, ready high: one word every two cycles.
    step(0, 0, 0, 1);
    lit("first_req", {31'd0, imem_req}, 32'd1);
    lit("first_addr", imem_addr, 32'h100);
    step(0, 0, 1, 1);
    lit("seq_valid0", {31'd0, instruction_valid}, 32'd1);
    lit("seq_ipc0", instruction_pc, 32'h100);
    step(0, 0, 0, 1);
    lit("seq_addr1", imem_addr, 32'h104);
    lit("seq_invalid1", {31'd0, instruction_valid}, 32'd0);
    step(0, 0, 1, 1);
    lit("seq_ipc1", instruction_pc, 32'h104);
    step(0, 0, 0, 1);
    lit("seq_addr2", imem_addr, 32'h108);
    step(0, 0, 1, 1);

    // Backpressure: full buffer blocks new requests.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      lit("stall_req", {31'd0, imem_req}, 32'd0);
      lit("stall_ipc", instruction_pc, 32'h108);
    end
    step(0, 0, 0, 1);
    lit("unstall_addr", imem_addr, 32'h10C);
    lit("unstall_req", {31'd0, imem_req}, 32'd1);

    // Redirect during a slow fetch: request held, acked word dropped.
    step(1, 32'h200, 0, 1);
    lit("flush_addr", imem_addr, 32'h10C);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    lit("flush_held", {31'd0, imem_req}, 32'd1);
    step(0, 0, 1, 1);
    lit("flush_drop", {31'd0, instruction_valid}, 32'd0);
    step(0, 0, 0, 1);
    lit("flush_next", imem_addr, 32'h200);

    // Redirect coinciding with ack.
    step(1, 32'h300, 1, 1);
    lit("rack_valid", {31'd0, instruction_valid}, 32'd0);
    step(0, 0, 0, 1);
    lit("rack_next", imem_addr, 32'h300);
    step(0, 0, 1, 1);
    step(1, 32'h304, 0, 1);
    lit("rpop_valid", {31'd0, instruction_valid}, 32'd0);
    step(0, 0, 0, 1);
    lit("rpop_next", imem_addr, 32'h304);

    // Misaligned redirect faults; aligned redirect recovers.
    step(0, 0, 1, 1);
    step(1, 32'h302, 0, 1);
    lit("fault_set", {31'd0, fetch_fault}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      lit("fault_noreq", {31'd0, imem_req}, 32'd0);
    end
    step(1, 32'h400, 0, 1);
    lit("fault_clr", {31'd0, fetch_fault}, 32'd0);
    step(0, 0, 0, 1);
    lit("fault_fetch", imem_addr, 32'h400);
    step(0, 0, 1, 1);

    // PC wrap.
    step(1, 32'hFFFF_FFFC, 0, 1);
    step(0, 0, 0, 1);
    lit("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 1, 1);
    lit("wrap_ipc", instruction_pc, 32'hFFFF_FFFC);
    step(0, 0, 0, 1);
    lit("wrap_addr1", imem_addr, 32'h0);

    // Asynchronous reset mid-FETCH with a late ack.
    #3;
    rst_n = 1'b0;
    imem_ack = 1'b1;
    #1;
    lit("arst_req", {31'd0, imem_req}, 32'd0);
    lit("arst_addr", imem_addr, 32'h100);
    lit("arst_valid", {31'd0, instruction_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_ack = 1'b0;
    model_reset();
    compare_model();
    step(0, 0, 1, 1);
    lit("arst_refetch", imem_addr, 32'h100);
    lit("arst_refetch_req", {31'd0, imem_req}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(15) == 0);
      rpc = $urandom & 32'h0000_0FFC;
      if ($urandom_range(3) == 0) rpc = rpc | 32'($urandom_range(1, 3));
      if ($urandom_range(31) == 0) rpc = 32'hFFFF_FFFC;
      ack = m_req ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
      rdy = ($urandom_range(3) != 0);
      step(r, rpc, ack, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
